// File: rtl/ascon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ascon_pkg
// Description : Shared definitions for the ASCON host interface. Holds the
//               host command opcodes, core operation-mode codes, register
//               write-back select codes, nonce shift selects, the host FSM
//               encoding and a byte-extraction helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ascon_pkg;

  // Command byte opcode field [7:6]
  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_START = 2'b10,
    OP_NOP   = 2'b11
  } opcode_e;

  // Operation modes forwarded to the core on start
  typedef enum logic [2:0] {
    MODE_IDLE     = 3'd0,
    MODE_AEAD_ENC = 3'd1,
    MODE_AEAD_DEC = 3'd2,
    MODE_HASH     = 3'd3
  } op_mode_e;

  // Register select codes; shared by host targets and core write-back
  localparam logic [1:0] REG0_WRBACK_SEL = 2'd0;
  localparam logic [1:0] REG1_WRBACK_SEL = 2'd1;
  localparam logic [1:0] REG2_WRBACK_SEL = 2'd2;
  localparam logic [1:0] TGT_NONCE       = 2'd3;

  // Core state words targeted by the nonce serializer
  localparam logic [2:0] NONCE_SEL_S3 = 3'd3;
  localparam logic [2:0] NONCE_SEL_S4 = 3'd4;

  // Index of the final byte of every 16-byte transfer
  localparam logic [3:0] LAST_BYTE_IDX = 4'hF;

  // Host interface FSM encoding
  typedef enum logic [2:0] {
    ST_CMD         = 3'd0,
    ST_WR_DATA     = 3'd1,
    ST_NONCE_SHIFT = 3'd2,
    ST_START       = 3'd3,
    ST_BUSY        = 3'd4
`ifdef ASCON_HOST_IF_READBACK_EN
    , ST_RD_DATA   = 3'd5
`endif
  } state_e;

  // Byte idx of a 128-bit word, counted from the MSB (idx 0 = bits 127:120)
  function automatic logic [7:0] reg_byte(input logic [127:0] r,
                                          input logic [3:0]   idx);
    logic [127:0] t;
    t = r << {idx, 3'b000};
    return t[127:120];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_nonce_ser.sv
`default_nettype none
// ============================================================================
// Module      : ascon_nonce_ser
// Description : Nonce bit serializer. A byte loaded on load_i is shifted out
//               MSB first over the following 8 cycles with shift_en_o high;
//               done_o pulses during the eighth (last) bit cycle.
// Ports       : clk, rst_n     - clock, async active-low reset
//               load_i, byte_i - byte load strobe and data
//               shift_en_o     - a bit is valid on bit_o this cycle
//               bit_o          - current serial bit
//               done_o         - last bit of the byte is on bit_o
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_nonce_ser (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       shift_en_o,
  output logic       bit_o,
  output logic       done_o
);

  logic [7:0] sh_q;
  logic [2:0] bit_cnt_q;
  logic       active_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q      <= '0;
      bit_cnt_q <= '0;
      active_q  <= 1'b0;
    end else if (load_i) begin
      sh_q      <= byte_i;
      bit_cnt_q <= '0;
      active_q  <= 1'b1;
    end else if (active_q) begin
      sh_q      <= {sh_q[6:0], 1'b0};
      bit_cnt_q <= bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        active_q <= 1'b0;
      end
    end
  end

  assign shift_en_o = active_q;
  assign bit_o      = sh_q[7];
  assign done_o     = active_q && (bit_cnt_q == 3'd7);

endmodule
`default_nettype wire

// File: rtl/ascon_host_if.sv
`default_nettype none
// ============================================================================
// Module      : ascon_host_if
// Description : Byte-wide host interface for an ASCON core. Decodes command
//               bytes, loads the 128-bit key/text/AD registers, serially
//               loads the nonce into the core state, starts operations and
//               accepts register write-back from the core.
// Ports       : clk, rst_n                     - clock, async active-low reset
//               in_valid/in_ready/in_data      - host byte input
//               out_valid/out_ready/out_data   - register readback bytes
//               reg0/1/2_128b                  - registers to the core
//               operation_mode/operation_ready - start request to the core
//               state_shift_en/sel/lsb         - serial nonce load
//               reg_128b_wrback_*              - core register write-back
//               operation_done, busy           - completion / busy status
// Build option: ASCON_HOST_IF_READBACK_EN - enables the readback path; when
//               undefined, read commands are consumed and ignored and
//               out_valid is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_host_if
  import ascon_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic [127:0] reg0_128b,
  output logic [127:0] reg1_128b,
  output logic [127:0] reg2_128b,
  output logic [2:0]   operation_mode,
  output logic         operation_ready,
  output logic         state_shift_en,
  output logic [2:0]   state_shift_sel,
  output logic         state_shift_lsb,
  input  logic         reg_128b_wrback_en,
  input  logic [1:0]   reg_128b_wrback_sel,
  input  logic [127:0] reg_128b_wrback_val,
  input  logic         operation_done,
  output logic         busy
);

  state_e       state_q, state_d;
  logic [3:0]   byte_cnt_q, byte_cnt_d;
  logic [1:0]   target_q, target_d;
  logic [2:0]   mode_q, mode_d;
  logic [127:0] reg_q [3];

  logic         accept;
  logic         host_wr_en;
  logic         ser_load;
  logic         ser_done;
  logic         rd_valid;

  assign accept = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CMD;
      byte_cnt_q <= '0;
      target_q   <= '0;
      mode_q     <= MODE_IDLE;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      target_q   <= target_d;
      mode_q     <= mode_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    byte_cnt_d      = byte_cnt_q;
    target_d        = target_q;
    mode_d          = mode_q;
    in_ready        = 1'b0;
    operation_ready = 1'b0;
    busy            = 1'b0;
    ser_load        = 1'b0;
    host_wr_en      = 1'b0;
    rd_valid        = 1'b0;

    case (state_q)
      ST_CMD: begin
        in_ready = 1'b1;
        if (accept) begin
          case (in_data[7:6])
            OP_WRITE: begin
              target_d   = in_data[5:4];
              byte_cnt_d = '0;
              state_d    = ST_WR_DATA;
            end
`ifdef ASCON_HOST_IF_READBACK_EN
            OP_READ: begin
              // The nonce lives inside the core state and cannot be read back
              if (in_data[5:4] != TGT_NONCE) begin
                target_d   = in_data[5:4];
                byte_cnt_d = '0;
                state_d    = ST_RD_DATA;
              end
            end
`endif
            OP_START: begin
              mode_d  = in_data[2:0];
              state_d = ST_START;
            end
            default: begin
              // Unused opcodes are consumed without effect
            end
          endcase
        end
      end

      ST_WR_DATA: begin
        in_ready = 1'b1;
        if (accept) begin
          if (target_q == TGT_NONCE) begin
            // Byte counter advances when the serializer finishes the byte
            ser_load = 1'b1;
            state_d  = ST_NONCE_SHIFT;
          end else begin
            host_wr_en = 1'b1;
            byte_cnt_d = byte_cnt_q + 4'd1;
            if (byte_cnt_q == LAST_BYTE_IDX) begin
              state_d = ST_CMD;
            end
          end
        end
      end

      ST_NONCE_SHIFT: begin
        if (ser_done) begin
          byte_cnt_d = byte_cnt_q + 4'd1;
          state_d    = (byte_cnt_q == LAST_BYTE_IDX) ? ST_CMD : ST_WR_DATA;
        end
      end

      ST_START: begin
        operation_ready = 1'b1;
        busy            = 1'b1;
        state_d         = ST_BUSY;
      end

      ST_BUSY: begin
        busy = 1'b1;
        if (operation_done) begin
          state_d = ST_CMD;
        end
      end

`ifdef ASCON_HOST_IF_READBACK_EN
      ST_RD_DATA: begin
        rd_valid = 1'b1;
        if (out_ready) begin
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (byte_cnt_q == LAST_BYTE_IDX) begin
            state_d = ST_CMD;
          end
        end
      end
`endif

      default: begin
        state_d = ST_CMD;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Key/text/AD registers. Core write-back takes priority over a host byte
  // landing on the same register in the same cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        reg_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (reg_128b_wrback_en && (reg_128b_wrback_sel == 2'(i))) begin
          reg_q[i] <= reg_128b_wrback_val;
        end else if (host_wr_en && (target_q == 2'(i))) begin
          reg_q[i] <= {reg_q[i][119:0], in_data};
        end
      end
    end
  end

  assign reg0_128b      = reg_q[REG0_WRBACK_SEL];
  assign reg1_128b      = reg_q[REG1_WRBACK_SEL];
  assign reg2_128b      = reg_q[REG2_WRBACK_SEL];
  assign operation_mode = mode_q;

  // --------------------------------------------------------------------------
  // Nonce serializer: first 8 bytes go to S_3, the remaining 8 to S_4
  // --------------------------------------------------------------------------
  ascon_nonce_ser u_nonce_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ser_load),
    .byte_i     (in_data),
    .shift_en_o (state_shift_en),
    .bit_o      (state_shift_lsb),
    .done_o     (ser_done)
  );

  assign state_shift_sel = byte_cnt_q[3] ? NONCE_SEL_S4 : NONCE_SEL_S3;

  // --------------------------------------------------------------------------
  // Readback path
  // --------------------------------------------------------------------------
`ifdef ASCON_HOST_IF_READBACK_EN
  logic [127:0] rd_reg;

  always_comb begin
    rd_reg = reg_q[REG0_WRBACK_SEL];
    case (target_q)
      REG1_WRBACK_SEL: rd_reg = reg_q[REG1_WRBACK_SEL];
      REG2_WRBACK_SEL: rd_reg = reg_q[REG2_WRBACK_SEL];
      default:         rd_reg = reg_q[REG0_WRBACK_SEL];
    endcase
  end

  assign out_valid = rd_valid;
  assign out_data  = reg_byte(rd_reg, byte_cnt_q);
`else
  logic unused_rd;

  assign unused_rd = &{1'b0, out_ready, rd_valid};
  assign out_valid = 1'b0;
  assign out_data  = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ascon_host_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_ascon_host_if
// Description : Self-checking bench for ascon_host_if: register writes from a
//               vector table, then directed sequences for nonce shifting,
//               start/busy, core write-back, readback and mid-transfer reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ascon_host_if;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic [127:0] reg0_128b;
  logic [127:0] reg1_128b;
  logic [127:0] reg2_128b;
  logic [2:0]   operation_mode;
  logic         operation_ready;
  logic         state_shift_en;
  logic [2:0]   state_shift_sel;
  logic         state_shift_lsb;
  logic         reg_128b_wrback_en;
  logic [1:0]   reg_128b_wrback_sel;
  logic [127:0] reg_128b_wrback_val;
  logic         operation_done;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  ascon_host_if dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_data             (in_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_data            (out_data),
    .reg0_128b           (reg0_128b),
    .reg1_128b           (reg1_128b),
    .reg2_128b           (reg2_128b),
    .operation_mode      (operation_mode),
    .operation_ready     (operation_ready),
    .state_shift_en      (state_shift_en),
    .state_shift_sel     (state_shift_sel),
    .state_shift_lsb     (state_shift_lsb),
    .reg_128b_wrback_en  (reg_128b_wrback_en),
    .reg_128b_wrback_sel (reg_128b_wrback_sel),
    .reg_128b_wrback_val (reg_128b_wrback_val),
    .operation_done      (operation_done),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]   tgt;
    logic [127:0] data;
    logic [127:0] e0;
    logic [127:0] e1;
    logic [127:0] e2;
  } wr_vec_t;

  wr_vec_t vecs [4];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send_byte(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_byte_timeout: got in_ready=0, expected 1");
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] d);
    logic [127:0] t;
    t = d;
    for (int i = 0; i < 16; i++) begin
      send_byte(t[127:120]);
      t = t << 8;
    end
  endtask

  logic [127:0] exp0, exp1, exp2, tmp;
  int           idx, n;
  logic         seen;

  initial begin
    vecs[0] = '{2'd0, 128'h000102030405060708090A0B0C0D0E0F,
                128'h000102030405060708090A0B0C0D0E0F, 128'h0, 128'h0};
    vecs[1] = '{2'd1, 128'hFFEEDDCCBBAA99887766554433221100,
                128'h000102030405060708090A0B0C0D0E0F,
                128'hFFEEDDCCBBAA99887766554433221100, 128'h0};
    vecs[2] = '{2'd2, 128'hDEADBEEF0BADF00DCAFEBABE12345678,
                128'h000102030405060708090A0B0C0D0E0F,
                128'hFFEEDDCCBBAA99887766554433221100,
                128'hDEADBEEF0BADF00DCAFEBABE12345678};
    vecs[3] = '{2'd0, 128'h0F0E0D0C0B0A09080706050403020100,
                128'h0F0E0D0C0B0A09080706050403020100,
                128'hFFEEDDCCBBAA99887766554433221100,
                128'hDEADBEEF0BADF00DCAFEBABE12345678};

    rst_n               = 1'b0;
    in_valid            = 1'b0;
    in_data             = 8'h00;
    out_ready           = 1'b0;
    reg_128b_wrback_en  = 1'b0;
    reg_128b_wrback_sel = 2'd0;
    reg_128b_wrback_val = '0;
    operation_done      = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    chk("rst_regs", {reg0_128b ^ reg1_128b ^ reg2_128b}, 128'h0);
    chk("rst_reg0", reg0_128b, 128'h0);
    chk("rst_outs", {125'h0, operation_ready, state_shift_en, out_valid}, 128'h0);
    chk("rst_busy_mode", {124'h0, busy, operation_mode}, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {127'h0, in_ready}, 128'h1);

    // ---------------- table-driven register writes ----------------
    for (int v = 0; v < 4; v++) begin
      send_byte({2'b00, vecs[v].tgt, 4'h0});
      send_block(vecs[v].data);
      chk($sformatf("wr%0d_reg0", v), reg0_128b, vecs[v].e0);
      chk($sformatf("wr%0d_reg1", v), reg1_128b, vecs[v].e1);
      chk($sformatf("wr%0d_reg2", v), reg2_128b, vecs[v].e2);
    end
    exp0 = vecs[3].e0;
    exp1 = vecs[3].e1;

    // ---------------- write-back beats same-cycle host byte ----------------
    send_byte(8'h20);
    in_valid            = 1'b1;
    in_data             = 8'h11;
    reg_128b_wrback_en  = 1'b1;
    reg_128b_wrback_sel = 2'd2;
    reg_128b_wrback_val = {16{8'hCC}};
    @(posedge clk);
    @(negedge clk);
    in_valid           = 1'b0;
    reg_128b_wrback_en = 1'b0;
    chk("wb_prio_reg2", reg2_128b, {16{8'hCC}});
    for (int b = 1; b < 16; b++) send_byte(8'(b));
    exp2 = 128'hCC0102030405060708090A0B0C0D0E0F;
    chk("wb_prio_final", reg2_128b, exp2);

    // ---------------- nonce serial load ----------------
    send_byte(8'h30);
    send_byte(8'h80);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("nonce_bit%0d", k),
          {122'h0, state_shift_en, state_shift_sel, state_shift_lsb, in_ready},
          {122'h0, 1'b1, 3'd3, (k == 0), 1'b0});
      @(negedge clk);
    end
    chk("nonce_gap", {126'h0, state_shift_en, in_ready}, 128'h1);
    for (int b = 1; b < 16; b++) begin
      send_byte(8'h00);
      if (b == 8)
        chk("nonce_sel4", {124'h0, state_shift_en, state_shift_sel}, {124'h0, 1'b1, 3'd4});
    end
    repeat (8) @(negedge clk);
    chk("nonce_end", {126'h0, state_shift_en, in_ready}, 128'h1);
    chk("nonce_regs", reg0_128b ^ reg1_128b ^ reg2_128b, exp0 ^ exp1 ^ exp2);

    // ---------------- start / busy / write-back ----------------
    send_byte(8'h81);
    chk("start_pulse",
        {122'h0, operation_ready, busy, in_ready, operation_mode},
        {122'h0, 1'b1, 1'b1, 1'b0, 3'd1});
    @(negedge clk);
    chk("start_busy", {125'h0, operation_ready, busy, in_ready}, {125'h0, 3'b010});
    reg_128b_wrback_en  = 1'b1;
    reg_128b_wrback_sel = 2'd1;
    reg_128b_wrback_val = {16{8'hAA}};
    @(negedge clk);
    reg_128b_wrback_sel = 2'd3;
    reg_128b_wrback_val = {16{8'h55}};
    exp1 = {16{8'hAA}};
    chk("wb_reg1", reg1_128b, exp1);
    @(negedge clk);
    reg_128b_wrback_en = 1'b0;
    chk("wb_sel3_reg0", reg0_128b, exp0);
    chk("wb_sel3_reg1", reg1_128b, exp1);
    chk("wb_sel3_reg2", reg2_128b, exp2);
    chk("busy_hold", {127'h0, busy}, 128'h1);
    operation_done = 1'b1;
    @(negedge clk);
    operation_done = 1'b0;
    chk("done_busy", {125'h0, busy, in_ready, operation_ready}, {125'h0, 3'b010});

    // ---------------- readback ----------------
`ifdef ASCON_HOST_IF_READBACK_EN
    send_byte(8'h40);
    idx = 0;
    n   = 0;
    while (idx < 16 && n < 200) begin
      out_ready = n[0];
      if (out_valid && out_ready) begin
        tmp = exp0 << (8 * idx);
        chk($sformatf("rd_byte%0d", idx), {120'h0, out_data}, {120'h0, tmp[127:120]});
        idx++;
      end
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    chk("rd_count", 128'(idx), 128'd16);
    chk("rd_end", {126'h0, out_valid, in_ready}, 128'h1);
    send_byte(8'h70);
    chk("rd_nonce_ignored", {126'h0, out_valid, in_ready}, 128'h1);
`else
    send_byte(8'h40);
    seen = 1'b0;
    out_ready = 1'b1;
    repeat (20) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("no_rd_valid", {127'h0, seen}, 128'h0);
    chk("no_rd_in_ready", {127'h0, in_ready}, 128'h1);
`endif

    // ---------------- opcode 11 ignored ----------------
    send_byte(8'hC0);
    chk("nop_state", {125'h0, in_ready, busy, operation_ready}, {125'h0, 3'b100});
    chk("nop_regs", reg0_128b, exp0);

    // ---------------- reset mid-write ----------------
    send_byte(8'h10);
    for (int b = 0; b < 5; b++) send_byte(8'h11 + 8'(b));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_reg0", reg0_128b, 128'h0);
    chk("mid_rst_reg1", reg1_128b, 128'h0);
    chk("mid_rst_reg2", reg2_128b, 128'h0);
    chk("mid_rst_mode", {125'h0, operation_mode}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", {127'h0, in_ready}, 128'h1);
    send_byte(8'h10);
    send_block(vecs[1].data);
    chk("post_rst_reg1", reg1_128b, vecs[1].data);
    chk("post_rst_reg0", reg0_128b, 128'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ascon_host_if.md
ASCON_HOST_IF -- requirements
Module: ascon_host_if

Interface
REQ-001 SHALL have clk, input, 1, clock; all logic on its rising edge.
REQ-002 SHALL have rst_n, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have in_valid/in_ready, input/output, 1 each, host byte handshake; in_data, input, 8, host byte.
REQ-004 SHALL have out_valid/out_ready, output/input, 1 each, readback handshake; out_data, output, 8, readback byte.
REQ-005 SHALL have reg0_128b, reg1_128b, reg2_128b, outputs, 128 each: key/text/AD registers to the core.
REQ-006 SHALL have operation_mode, output, 3; operation_ready, output, 1: start pulse to the core.
REQ-007 SHALL have state_shift_en, output, 1; state_shift_sel, output, 3; state_shift_lsb, output, 1: serial nonce load into core S_3/S_4.
REQ-008 SHALL have reg_128b_wrback_en, input, 1; reg_128b_wrback_sel, input, 2; reg_128b_wrback_val, input, 128; operation_done, input, 1: from the core.
REQ-009 SHALL have busy, output, 1, high from start until operation_done.

Function
REQ-010 SHALL run FSM states CMD, WR_DATA, NONCE_SHIFT, RD_DATA, START, BUSY; all bytes accepted on in_valid&in_ready.
REQ-011 SHALL decode command byte: [7:6] opcode (00 write, 01 read, 10 start, 11 ignored), [5:4] target (0..2 = reg0..reg2, 3 = nonce), [2:0] mode for start.
REQ-012 SHALL, on write to reg0..reg2, accept exactly 16 bytes MSB first, shifting each into the selected register (reg <= {reg[119:0], byte}), then return to CMD.
REQ-013 SHALL, on write to target 3, per byte drop in_ready and emit 8 cycles of state_shift_en=1, MSB first on state_shift_lsb; sel=3 for bytes 0-7, sel=4 for bytes 8-15; return to CMD after byte 15.
REQ-014 SHALL, on read (targets 0..2), emit 16 bytes MSB first on out_data with out_valid, advancing only on out_ready; target 3 read is ignored.
REQ-015 SHALL, on start, latch mode into operation_mode, assert operation_ready for exactly one cycle (START), then enter BUSY with busy=1.
REQ-016 SHALL hold in_ready=0 in START, BUSY, NONCE_SHIFT bit cycles, and RD_DATA; in_ready=1 in CMD and WR_DATA.
REQ-017 SHALL, in any state, load reg_128b_wrback_val into register sel (0/1/2) in the cycle wrback_en=1; sel=3 is ignored; wrback wins over a same-cycle host byte write.
REQ-018 SHALL leave BUSY for CMD the cycle after operation_done=1, dropping busy.
REQ-019 SHALL ignore opcode 11 (stay in CMD, consume byte).
REQ-020 SHALL use a 4-bit byte counter wrapping 15->0 at the end of each transfer, and a 3-bit bit counter.

Reset
REQ-021 SHALL, on rst_n low, immediately clear regs to 0, state to CMD, counters to 0, operation_mode to 0, and outputs operation_ready, state_shift_en, out_valid, busy to 0, with in_ready=1 after release.
REQ-022 SHALL abandon any partial transfer on reset mid-operation; no partial register content is preserved.

Configuration
REQ-023 SHALL compile readback only when ASCON_HOST_IF_READBACK_EN is defined; without it, RD_DATA is absent, opcode 01 is treated as opcode 11, and out_valid is tied 0.

Structure
REQ-024 SHALL take opcodes, operation-mode codes, writeback-select codes (REG0/1/2_WRBACK_SEL = 0/1/2), and FSM encodings from shared package ascon_pkg.
REQ-025 SHALL place the nonce bit serializer (byte in, 8-cycle shift-out, done pulse) in sub-module ascon_nonce_ser.

Verification
REQ-026 SHALL check write: cmd 0x00 then bytes 0x00..0x0F -> reg0_128b = 0x000102030405060708090A0B0C0D0E0F.
REQ-027 SHALL check nonce: cmd 0x30, byte 0x80 -> 8 cycles shift_en=1, sel=3, lsb=1 then 0x7 zeros; in_ready low throughout.
REQ-028 SHALL check start: cmd 0x81 -> operation_mode=1, one-cycle operation_ready, busy=1; operation_done -> busy=0 next cycle.
REQ-029 SHALL check writeback: during BUSY, wrback_en=1, sel=1, val=0xAA..AA -> reg1_128b=0xAA..AA; sel=3 leaves regs unchanged.
REQ-030 SHALL check readback (macro defined): cmd 0x40 with out_ready toggling -> 16 bytes equal reg0 MSB first, no loss; macro undefined -> out_valid never 1.
REQ-031 SHALL check reset asserted after 5 of 16 write bytes -> reg cleared, state CMD, next cmd decoded normally.
